// File: rtl/user_proj_pkg.sv
// Shared definitions for the Wishbone counter/timer array.
// Register offsets, CTRL bit positions and the per-channel control bundle.
package user_proj_pkg;

    localparam int MPRJ_IO = 38;

    localparam logic [7:0] CH_STRIDE = 8'h10;

    localparam logic [3:0] REG_CTRL    = 4'h0;
    localparam logic [3:0] REG_COUNT   = 4'h4;
    localparam logic [3:0] REG_COMPARE = 4'h8;
    localparam logic [3:0] REG_STATUS  = 4'hC;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;

    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ch_ctrl_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) res[b*8 +: 8] = data[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/user_proj_counter_array_if.sv
// Wishbone slave bundle between the management SoC and the counter array.
interface user_proj_counter_array_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_proj_counter_ch.sv
// One counter channel: count, compare, sticky match and CTRL.
// USER_PROJ_LA_OVERRIDE_EN enables the logic-analyzer override hook.
module user_proj_counter_ch
    import user_proj_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ctrl,
    input  logic             wr_count,
    input  logic             wr_compare,
    input  logic             wr_status,
    input  logic [3:0]       wr_sel,
    input  logic [31:0]      wr_data,
    input  logic [WIDTH-1:0] ovr_drive,
    input  logic [WIDTH-1:0] ovr_data,
    input  logic             ovr_hold,
    output ch_ctrl_t         ctrl,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] compare,
    output logic             match
);

    logic             en_eff;
    logic             hit;
    logic             clr;
    logic [31:0]      cnt_m;
    logic [31:0]      cmp_m;
    logic [WIDTH-1:0] count_base;
    logic [WIDTH-1:0] count_nxt;

    assign hit = en_eff && (count == compare);
    assign clr = wr_status && wr_sel[0] && wr_data[0];
    assign cnt_m = byte_merge(32'(count), wr_data, wr_sel);
    assign cmp_m = byte_merge(32'(compare), wr_data, wr_sel);

    always_comb begin
        count_base = count;
        if (wr_count)
            count_base = cnt_m[WIDTH-1:0];
        else if (en_eff)
            count_base = (hit && ctrl.auto_reload) ? '0
                       : count + WIDTH'(1);
    end

`ifdef USER_PROJ_LA_OVERRIDE_EN
    // LA-driven bits replace whatever the bus or increment produced
    assign en_eff = ctrl.en && !ovr_hold;
    assign count_nxt = (count_base & ~ovr_drive)
                     | (ovr_data & ovr_drive);
`else
    logic unused_ovr;
    assign unused_ovr = ^{ovr_drive, ovr_data, ovr_hold};
    assign en_eff = ctrl.en;
    assign count_nxt = count_base;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '0;
            count   <= '0;
            compare <= '1;
            match   <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_ctrl && wr_sel[0])
                ctrl <= '{auto_reload: wr_data[CTRL_AUTO_RELOAD],
                          irq_en:      wr_data[CTRL_IRQ_EN],
                          en:          wr_data[CTRL_EN]};
            if (wr_compare)
                compare <= cmp_m[WIDTH-1:0];
            // a fresh match outranks a same-cycle clear
            match <= hit || (match && !clr);
        end
    end

endmodule

// File: rtl/user_proj_counter_array.sv
// Wishbone-mapped array of NUM_CH counter/timer channels with IRQ.
// Optional LA override of channel 0 under USER_PROJ_LA_OVERRIDE_EN.
module user_proj_counter_array
    import user_proj_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int IO_BITS = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    user_proj_counter_array_if.slave   wb,
    input  logic [127:0]               la_data_in,
    input  logic [127:0]               la_oenb,
    output logic [127:0]               la_data_out,
    output logic [MPRJ_IO-1:0]         io_out,
    output logic [MPRJ_IO-1:0]         io_oeb,
    output logic [2:0]                 user_irq
);

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              irq_q;
    logic              req;
    logic              mapped;
    logic              wr_req;
    logic [3:0]        ch_idx;
    logic [3:0]        off;
    logic [31:0]       rdata;
    logic [WIDTH-1:0]  la_drive;
    logic [WIDTH-1:0]  la_val;
    logic              la_hold;
    ch_ctrl_t          ctrl    [NUM_CH];
    logic [WIDTH-1:0]  count   [NUM_CH];
    logic [WIDTH-1:0]  compare [NUM_CH];
    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] irq_en;

    logic unused_top;
    assign unused_top = ^{wb.wbs_adr_i[31:8], la_data_in, la_oenb};

    assign req    = wb.wbs_cyc_i && wb.wbs_stb_i && !ack_q;
    assign ch_idx = 4'(wb.wbs_adr_i[7:0] / CH_STRIDE);
    assign off    = 4'(wb.wbs_adr_i[7:0] % CH_STRIDE);
    assign mapped = (off[1:0] == 2'b00) && (32'(ch_idx) < NUM_CH);
    assign wr_req = req && wb.wbs_we_i && mapped;

`ifdef USER_PROJ_LA_OVERRIDE_EN
    assign la_drive = ~la_oenb[WIDTH-1:0];
    assign la_val   = la_data_in[WIDTH-1:0];
    assign la_hold  = la_data_in[65];
`else
    assign la_drive = '0;
    assign la_val   = '0;
    assign la_hold  = 1'b0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel_c;
        assign sel_c = wr_req && (ch_idx == 4'(c));
        assign irq_en[c] = ctrl[c].irq_en;

        user_proj_counter_ch #(.WIDTH(WIDTH)) u_ch (
            .clk        (wb_clk_i),
            .rst        (wb_rst_i),
            .wr_ctrl    (sel_c && off == REG_CTRL),
            .wr_count   (sel_c && off == REG_COUNT),
            .wr_compare (sel_c && off == REG_COMPARE),
            .wr_status  (sel_c && off == REG_STATUS),
            .wr_sel     (wb.wbs_sel_i),
            .wr_data    (wb.wbs_dat_i),
            .ovr_drive  (c == 0 ? la_drive : '0),
            .ovr_data   (c == 0 ? la_val : '0),
            .ovr_hold   (c == 0 ? la_hold : 1'b0),
            .ctrl       (ctrl[c]),
            .count      (count[c]),
            .compare    (compare[c]),
            .match      (match[c])
        );
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mapped && ch_idx == 4'(c)) begin
                case (off)
                    REG_CTRL:    rdata = 32'(ctrl[c]);
                    REG_COUNT:   rdata = 32'(count[c]);
                    REG_COMPARE: rdata = 32'(compare[c]);
                    REG_STATUS:  rdata = 32'(match[c]);
                    default:     rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wb.wbs_we_i) ? rdata : '0;
            irq_q <= |(match & irq_en);
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign user_irq     = {2'b00, irq_q};

    always_comb begin
        la_data_out = '0;
        la_data_out[WIDTH-1:0] = count[0];
        la_data_out[64 +: NUM_CH] = match;
    end

    assign io_out = {{(MPRJ_IO-IO_BITS){1'b0}},
                     count[0][IO_BITS-1:0]};
    assign io_oeb = {{(MPRJ_IO-IO_BITS){1'b1}},
                     {IO_BITS{1'b0}}};

endmodule

// File: tb/tb_user_proj_counter_array.sv
// Bench for user_proj_counter_array: register-level model plus
// directed Wishbone vectors with literal expectations.
module tb_user_proj_counter_array;
    import user_proj_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [2:0]   user_irq;

    user_proj_counter_array_if wb();

    user_proj_counter_array #(
        .NUM_CH(4), .WIDTH(32), .IO_BITS(16)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wb),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .user_irq    (user_irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    function automatic void check(string name, logic [127:0] act,
                                  logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endfunction

    // Register-level model: the four registers per channel as plain values
    logic [31:0] m_cnt [4];
    logic [31:0] m_cmp [4];
    logic [2:0]  m_ctl [4];
    bit          m_mat [4];
    bit          m_irq;
    bit          m_ack;
    logic [31:0] m_dat;

    function automatic bit acc();
        return wb.wbs_cyc_i && wb.wbs_stb_i && !m_ack;
    endfunction

    function automatic bit wr(int c, int r);
        return acc() && wb.wbs_we_i
            && wb.wbs_adr_i[7:0] == 8'(c * 16 + r * 4);
    endfunction

    function automatic bit la_hold();
`ifdef USER_PROJ_LA_OVERRIDE_EN
        return la_data_in[65];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit en_of(int c);
        return m_ctl[c][0] && !(c == 0 && la_hold());
    endfunction

    function automatic bit hit(int c);
        return en_of(c) && m_cnt[c] == m_cmp[c];
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (wb.wbs_sel_i[b]) r[b*8 +: 8] = wb.wbs_dat_i[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] nxt_cnt(int c);
        logic [31:0] v;
        if (wr(c, 1)) v = merge(m_cnt[c]);
        else if (en_of(c))
            v = (hit(c) && m_ctl[c][2]) ? 32'd0 : m_cnt[c] + 32'd1;
        else v = m_cnt[c];
`ifdef USER_PROJ_LA_OVERRIDE_EN
        if (c == 0)
            v = (v & la_oenb[31:0]) | (la_data_in[31:0] & ~la_oenb[31:0]);
`endif
        return v;
    endfunction

    function automatic logic [31:0] rd_of(logic [7:0] a);
        int ch;
        ch = int'(a) / 16;
        if (a[1:0] != 2'b00 || ch >= 4) return 32'd0;
        case (a[3:2])
            2'd0:    return {29'd0, m_ctl[ch]};
            2'd1:    return m_cnt[ch];
            2'd2:    return m_cmp[ch];
            default: return {31'd0, m_mat[ch]};
        endcase
    endfunction

    function automatic bit irq_calc();
        bit r;
        r = 1'b0;
        for (int c = 0; c < 4; c++) r = r | (m_mat[c] & m_ctl[c][1]);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_cnt[c] <= 32'd0;
                m_cmp[c] <= 32'hFFFF_FFFF;
                m_ctl[c] <= 3'd0;
                m_mat[c] <= 1'b0;
            end
            m_irq <= 1'b0;
            m_ack <= 1'b0;
            m_dat <= 32'd0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (wr(c, 0) && wb.wbs_sel_i[0])
                    m_ctl[c] <= wb.wbs_dat_i[2:0];
                if (wr(c, 2)) m_cmp[c] <= merge(m_cmp[c]);
                m_cnt[c] <= nxt_cnt(c);
                m_mat[c] <= hit(c) || (m_mat[c] && !(wr(c, 3)
                            && wb.wbs_sel_i[0] && wb.wbs_dat_i[0]));
            end
            m_irq <= irq_calc();
            m_ack <= acc();
            m_dat <= (acc() && !wb.wbs_we_i)
                   ? rd_of(wb.wbs_adr_i[7:0]) : 32'd0;
        end
    end

    function automatic logic [127:0] exp_la();
        logic [127:0] v;
        v = '0;
        v[31:0] = m_cnt[0];
        for (int c = 0; c < 4; c++) v[64 + c] = m_mat[c];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", wb.wbs_ack_o, m_ack);
            if (m_ack) check("rdata", wb.wbs_dat_o, m_dat);
            check("irq", user_irq, {2'b00, m_irq});
            check("la_out", la_data_out, exp_la());
            check("io_out", io_out, {22'd0, m_cnt[0][15:0]});
            check("io_oeb", io_oeb, {22'h3F_FFFF, 16'h0000});
        end
    end

    task automatic xfer(input bit w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r);
        int n;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = w;
        wb.wbs_adr_i = {24'd0, a};
        wb.wbs_dat_i = d;
        wb.wbs_sel_i = s;
        for (n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) break;
        end
        check("ack_lat", 128'(n), 128'd1);
        r = wb.wbs_dat_o;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        logic [31:0] r;
        xfer(1'b1, a, d, s, r);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, 4'hF, r);
        check(name, r, exp);
    endtask

    initial begin
        rst = 1'b1;
        la_data_in = '0;
        la_oenb = '1;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ack", wb.wbs_ack_o, 0);
        check("rst_dat", wb.wbs_dat_o, 0);
        check("rst_irq", user_irq, 0);
        rst = 1'b0;

        // reset values of every register
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd_chk("reset_reg", 8'(c * 16 + r * 4),
                       r == 2 ? 32'hFFFF_FFFF : 32'd0);

        // ch1 auto-reload at 5 with interrupt
        wr_reg(8'h18, 32'd5, 4'hF);
        wr_reg(8'h10, 32'h7, 4'hF);
        repeat (4) @(negedge clk);
        check("ch1_nomatch", la_data_out[65], 0);
        @(negedge clk);
        check("ch1_match", la_data_out[65], 1);
        check("ch1_irq_lag", user_irq, 0);
        @(negedge clk);
        check("ch1_irq", user_irq, 3'b001);
        wr_reg(8'h10, 32'h6, 4'hF);
        wr_reg(8'h1C, 32'h1, 4'hF);
        check("ch1_w1c", la_data_out[65], 0);
        check("ch1_irq_drop", user_irq, 0);

        // ch2 wraps from 0xFFFFFFFE, compare 0x10, no irq_en
        wr_reg(8'h24, 32'hFFFF_FFFE, 4'hF);
        wr_reg(8'h28, 32'h10, 4'hF);
        wr_reg(8'h20, 32'h1, 4'hF);
        rd_chk("ch2_top", 8'h24, 32'hFFFF_FFFF);
        rd_chk("ch2_wrap", 8'h24, 32'd1);
        rd_chk("ch2_nomatch", 8'h2C, 32'd0);
        repeat (30) @(negedge clk);
        rd_chk("ch2_match", 8'h2C, 32'd1);
        check("ch2_flag", la_data_out[66], 1);
        check("ch2_noirq", user_irq, 0);

        // byte-lane write beats the increment on running ch0
        wr_reg(8'h00, 32'h1, 4'hF);
        wr_reg(8'h04, 32'h100, 4'b0010);
        check("ch0_sel", la_data_out[31:0], 32'h102);
        check("ch0_io", io_out[15:0], 16'h0102);

        // unmapped offsets
        wr_reg(8'h40, 32'hDEAD_BEEF, 4'hF);
        rd_chk("unmap_rd", 8'h40, 32'd0);
        wr_reg(8'h0A, 32'd0, 4'hF);
        rd_chk("unmap_nowr", 8'h08, 32'hFFFF_FFFF);
        rd_chk("ch2_keep", 8'h28, 32'h10);
        rd_chk("misalign_rd", 8'h2A, 32'd0);

        // reset in the middle of a strobe
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_adr_i = 32'h28;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_noack", wb.wbs_ack_o, 0);
        end
        rst = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        @(negedge clk);
        rd_chk("post_rst_cnt", 8'h14, 32'd0);
        rd_chk("post_rst_cmp", 8'h28, 32'hFFFF_FFFF);
        rd_chk("post_rst_st", 8'h2C, 32'd0);
        check("post_rst_la", la_data_out, 0);

`ifdef USER_PROJ_LA_OVERRIDE_EN
        la_oenb = ~128'hFF;
        la_data_in = 128'hA5;
        wr_reg(8'h00, 32'h1, 4'hF);
        repeat (3) @(negedge clk);
        check("la_ovr", la_data_out[31:0], 32'hA5);
        la_oenb = '1;
        la_data_in = '0;
        repeat (2) @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
